// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and enums for the fetch/branch controller
package fetch_pkg;

    localparam int PC_W  = 10;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        ZERO   = 2'd1,
        INC    = 2'd2,
        BRANCH = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-PC mux with signed PC-relative adder
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int PC_W = fetch_pkg::PC_W
) (
    input  pc_sel_t          sel_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [PC_W-1:0]  lut_out_i,
    output logic [PC_W-1:0]  pc_next_o
);

    // Two's-complement offset: a plain PC_W-bit add wraps correctly in both directions.
    always_comb begin
        pc_next_o = pc_i;
        case (sel_i)
            HOLD:    pc_next_o = pc_i;
            ZERO:    pc_next_o = '0;
            INC:     pc_next_o = pc_i + {{(PC_W-1){1'b0}}, 1'b1};
            BRANCH:  pc_next_o = pc_i + lut_out_i;
            default: pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_branch_ctl.sv
// rtl/fetch_branch_ctl.sv - PC sequencer and branch resolution; FETCH_PERF_CNT_EN builds the perf counters
module fetch_branch_ctl
    import fetch_pkg::*;
#(
    parameter int PC_W  = fetch_pkg::PC_W,
    parameter int IDX_W = fetch_pkg::IDX_W,
    parameter int CNT_W = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Stall,
    input  logic              Halt,
    input  logic              BranchEn,
    input  logic              BranchCond,
    input  logic [IDX_W-1:0]  BranchIdx,
    output logic [IDX_W-1:0]  LutIndex,
    input  logic [PC_W-1:0]   LutOut,
    output logic [PC_W-1:0]   PC,
    output logic              Running,
    output logic              Done,
    output logic              BranchTaken,
    output logic [CNT_W-1:0]  CycleCnt,
    output logic [CNT_W-1:0]  TakenCnt
);

    fetch_state_t     state_q, state_d;
    pc_sel_t          pc_sel;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             running_q, done_q, taken_q;
    logic             cnt_clear, cnt_cycle, cnt_taken;

    assign LutIndex    = BranchIdx;
    assign PC          = pc_q;
    assign Running     = running_q;
    assign Done        = done_q;
    assign BranchTaken = taken_q;

    // Start in DONE deliberately ignores Stall so a frozen pipeline can still be relaunched.
    always_comb begin
        state_d   = state_q;
        pc_sel    = HOLD;
        cnt_clear = 1'b0;
        cnt_cycle = 1'b0;
        cnt_taken = 1'b0;
        case (state_q)
            IDLE: begin
                pc_sel = ZERO;
                if (!Stall && Start) state_d = RUN;
            end
            RUN: begin
                if (!Stall) begin
                    cnt_cycle = 1'b1;
                    if (Start) begin
                        pc_sel    = ZERO;
                        cnt_clear = 1'b1;
                    end else if (Halt) begin
                        state_d = DONE;
                    end else if (BranchEn && BranchCond) begin
                        pc_sel    = BRANCH;
                        cnt_taken = 1'b1;
                    end else begin
                        pc_sel = INC;
                    end
                end
            end
            DONE: begin
                if (Start) begin
                    state_d   = RUN;
                    pc_sel    = ZERO;
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pc_sel  = ZERO;
            end
        endcase
    end

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_pc_next_calc (
        .sel_i     (pc_sel),
        .pc_i      (pc_q),
        .lut_out_i (LutOut),
        .pc_next_o (pc_d)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
            taken_q   <= cnt_taken;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, taken_cnt_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cycle_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else if (cnt_clear) begin
            cycle_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (cnt_cycle && (cycle_cnt_q != '1))
                cycle_cnt_q <= cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_taken && (taken_cnt_q != '1))
                taken_cnt_q <= taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign CycleCnt = cycle_cnt_q;
    assign TakenCnt = taken_cnt_q;
`else
    assign CycleCnt = '0;
    assign TakenCnt = '0;
`endif

endmodule

// File: tb/tb_fetch_branch_ctl.sv
// tb/tb_fetch_branch_ctl.sv - directed bench for fetch_branch_ctl; counter expectations follow FETCH_PERF_CNT_EN
module tb_fetch_branch_ctl;

    logic        Clk;
    logic        Reset_n;
    logic        Start, Stall, Halt, BranchEn, BranchCond;
    logic [3:0]  BranchIdx, LutIndex;
    logic [9:0]  LutOut, PC;
    logic        Running, Done, BranchTaken;
    logic [15:0] CycleCnt, TakenCnt;

    int checks = 0;
    int errors = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_branch_ctl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Stall       (Stall),
        .Halt        (Halt),
        .BranchEn    (BranchEn),
        .BranchCond  (BranchCond),
        .BranchIdx   (BranchIdx),
        .LutIndex    (LutIndex),
        .LutOut      (LutOut),
        .PC          (PC),
        .Running     (Running),
        .Done        (Done),
        .BranchTaken (BranchTaken),
        .CycleCnt    (CycleCnt),
        .TakenCnt    (TakenCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] ec(input int n);
        return PERF ? n[15:0] : 16'd0;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        Start = 0; Stall = 0; Halt = 0; BranchEn = 0; BranchCond = 0; LutOut = '0;
    endtask

    task automatic test_reset();
        Reset_n = 0; idle_inputs(); BranchIdx = 4'h0;
        step(2);
        checks++; if (PC !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", PC); end
        checks++; if (Running !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL reset_state: running %b done %b expected 0 0", Running, Done); end
        checks++; if (BranchTaken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b expected 0", BranchTaken); end
        checks++; if (CycleCnt !== 16'd0 || TakenCnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", CycleCnt, TakenCnt); end
        Reset_n = 1;
        step(1);
    endtask

    task automatic test_start_and_step();
        Start = 1; step(1); Start = 0;
        checks++; if (Running !== 1'b1 || PC !== 10'd0) begin errors++; $display("FAIL start: running %b pc %0d expected 1 0", Running, PC); end
        step(4);
        checks++; if (PC !== 10'd4) begin errors++; $display("FAIL step4_pc: got %0d expected 4", PC); end
        checks++; if (CycleCnt !== ec(4)) begin errors++; $display("FAIL step4_cyc: got %0d expected %0d", CycleCnt, ec(4)); end
        BranchIdx = 4'hA; #1;
        checks++; if (LutIndex !== 4'hA) begin errors++; $display("FAIL lut_index: got %h expected a", LutIndex); end
    endtask

    task automatic test_branch_taken();
        Start = 1; step(1); Start = 0;
        checks++; if (PC !== 10'd0 || CycleCnt !== 16'd0) begin errors++; $display("FAIL restart: pc %0d cyc %0d expected 0 0", PC, CycleCnt); end
        step(500);
        checks++; if (PC !== 10'd500) begin errors++; $display("FAIL pc500: got %0d expected 500", PC); end
        BranchEn = 1; BranchCond = 1; LutOut = 10'h268;
        step(1); idle_inputs();
        checks++; if (PC !== 10'd92) begin errors++; $display("FAIL branch_pc: got %0d expected 92", PC); end
        checks++; if (BranchTaken !== 1'b1) begin errors++; $display("FAIL branch_pulse: got %b expected 1", BranchTaken); end
        checks++; if (TakenCnt !== ec(1) || CycleCnt !== ec(501)) begin errors++; $display("FAIL branch_cnt: got %0d/%0d expected %0d/%0d", TakenCnt, CycleCnt, ec(1), ec(501)); end
        step(1);
        checks++; if (BranchTaken !== 1'b0 || PC !== 10'd93) begin errors++; $display("FAIL branch_after: taken %b pc %0d expected 0 93", BranchTaken, PC); end
    endtask

    task automatic test_wrap();
        Start = 1; step(1); Start = 0;
        step(5);
        BranchEn = 1; BranchCond = 1; LutOut = 10'h268;
        step(1);
        checks++; if (PC !== 10'd621) begin errors++; $display("FAIL wrap_back: got %0d expected 621", PC); end
        LutOut = 10'd402;
        step(1); idle_inputs();
        checks++; if (PC !== 10'd1023) begin errors++; $display("FAIL pc1023: got %0d expected 1023", PC); end
        step(1);
        checks++; if (PC !== 10'd0) begin errors++; $display("FAIL wrap_fwd: got %0d expected 0", PC); end
        checks++; if (TakenCnt !== ec(2) || CycleCnt !== ec(8)) begin errors++; $display("FAIL wrap_cnt: got %0d/%0d expected %0d/%0d", TakenCnt, CycleCnt, ec(2), ec(8)); end
    endtask

    task automatic test_not_taken();
        step(10);
        BranchEn = 1; BranchCond = 0; LutOut = 10'd1;
        step(1);
        checks++; if (PC !== 10'd11 || BranchTaken !== 1'b0) begin errors++; $display("FAIL not_taken: pc %0d taken %b expected 11 0", PC, BranchTaken); end
        BranchEn = 0; BranchCond = 1; LutOut = 10'd100;
        step(1); idle_inputs();
        checks++; if (PC !== 10'd12 || BranchTaken !== 1'b0) begin errors++; $display("FAIL en_low: pc %0d taken %b expected 12 0", PC, BranchTaken); end
        checks++; if (TakenCnt !== ec(2) || CycleCnt !== ec(20)) begin errors++; $display("FAIL nt_cnt: got %0d/%0d expected %0d/%0d", TakenCnt, CycleCnt, ec(2), ec(20)); end
    endtask

    task automatic test_stall();
        Stall = 1; BranchEn = 1; BranchCond = 1; LutOut = 10'd7;
        step(3); idle_inputs();
        checks++; if (PC !== 10'd12 || Running !== 1'b1) begin errors++; $display("FAIL stall_pc: pc %0d running %b expected 12 1", PC, Running); end
        checks++; if (CycleCnt !== ec(20) || TakenCnt !== ec(2)) begin errors++; $display("FAIL stall_cnt: got %0d/%0d expected %0d/%0d", CycleCnt, TakenCnt, ec(20), ec(2)); end
    endtask

    task automatic test_halt();
        Halt = 1; BranchEn = 1; BranchCond = 1; LutOut = 10'd50;
        step(1); idle_inputs();
        checks++; if (Done !== 1'b1 || Running !== 1'b0 || PC !== 10'd12) begin errors++; $display("FAIL halt: done %b running %b pc %0d expected 1 0 12", Done, Running, PC); end
        checks++; if (BranchTaken !== 1'b0 || TakenCnt !== ec(2) || CycleCnt !== ec(21)) begin errors++; $display("FAIL halt_cnt: taken %b tk %0d cyc %0d expected 0 %0d %0d", BranchTaken, TakenCnt, CycleCnt, ec(2), ec(21)); end
        step(2);
        checks++; if (PC !== 10'd12 || Done !== 1'b1 || CycleCnt !== ec(21)) begin errors++; $display("FAIL done_frozen: pc %0d done %b cyc %0d expected 12 1 %0d", PC, Done, CycleCnt, ec(21)); end
        Start = 1; Stall = 1;
        step(1); idle_inputs();
        checks++; if (Running !== 1'b1 || Done !== 1'b0 || PC !== 10'd0 || CycleCnt !== 16'd0 || TakenCnt !== 16'd0) begin errors++; $display("FAIL done_restart: running %b done %b pc %0d cnt %0d/%0d expected 1 0 0 0/0", Running, Done, PC, CycleCnt, TakenCnt); end
    endtask

    task automatic test_async_reset();
        step(37);
        checks++; if (PC !== 10'd37) begin errors++; $display("FAIL pc37: got %0d expected 37", PC); end
        #2 Reset_n = 0;
        #1;
        checks++; if (PC !== 10'd0 || Running !== 1'b0 || Done !== 1'b0 || CycleCnt !== 16'd0 || TakenCnt !== 16'd0) begin errors++; $display("FAIL async_reset: pc %0d running %b done %b cnt %0d/%0d expected 0 0 0 0/0", PC, Running, Done, CycleCnt, TakenCnt); end
        step(1);
        Reset_n = 1;
        step(2);
        checks++; if (Running !== 1'b0 || PC !== 10'd0) begin errors++; $display("FAIL post_reset_idle: running %b pc %0d expected 0 0", Running, PC); end
    endtask

    initial begin
        test_reset();
        test_start_and_step();
        test_branch_taken();
        test_wrap();
        test_not_taken();
        test_stall();
        test_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
